// File: rtl/cpu_pkg.sv
// Shared CPU encodings: ALU opcodes, ALU execute FSM states and condition flags.
// The decode-side opcode translator and the execute ALU both import these.
package cpu_pkg;

   typedef enum logic [2:0] {
      ADDA = 3'd0,
      SUBA = 3'd1,
      MULA = 3'd2,
      DIVA = 3'd3,
      ANDA = 3'd4,
      ORA  = 3'd5,
      XORA = 3'd6,
      NOTA = 3'd7
   } alu_op_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_DIV,
      ST_DONE
   } alu_state_t;

   typedef struct packed {
      logic zero;
      logic neg;
      logic carry;
      logic ovf;
   } alu_flags_t;

endpackage

// File: rtl/alu_divider.sv
// Iterative restoring unsigned divider, one quotient bit per cycle, WIDTH cycles.
// done pulses during the final iteration; quotient and div_zero are valid with it.
// A zero divisor runs the full latency and naturally yields an all-ones quotient.
// Only instantiated when ALU_DIV_EN is defined.
module alu_divider #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic             div_zero
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic             busy;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dsr;
   logic [WIDTH-1:0] rem;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] quo_next;
   logic [WIDTH-1:0] rem_next;

   // One restoring step: shift in the next dividend bit, try to subtract the divisor.
   always_comb begin
      shifted  = {rem, quo[WIDTH-1]};
      trial    = shifted - {1'b0, dsr};
      quo_next = {quo[WIDTH-2:0], ~trial[WIDTH]};
      rem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
   end

   assign done     = busy && (cnt == LAST);
   assign quotient = quo_next;
   assign div_zero = busy && (dsr == '0);

   // Iteration state; reset abandons any divide in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= 1'b0;
         cnt  <= '0;
         quo  <= '0;
         dsr  <= '0;
         rem  <= '0;
      end else if (start) begin
         busy <= 1'b1;
         cnt  <= '0;
         quo  <= dividend;
         dsr  <= divisor;
         rem  <= '0;
      end else if (busy) begin
         quo <= quo_next;
         rem <= rem_next;
         cnt <= cnt + CW'(1);
         if (cnt == LAST) begin
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU. Logic ops and ADD/SUB complete in one registered cycle; MUL
// (inline shift-add) and DIV (alu_divider) take WIDTH iterations and stall via in_ready.
// Optional feature macro: ALU_DIV_EN instantiates the iterative divider; without it DIV
// completes in one cycle with result 0 and div_err set.
module alu_exec
   import cpu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       alu_op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             neg,
   output logic             carry,
   output logic             ovf,
   output logic             div_err
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   alu_state_t         state;
   alu_op_t            op;
   alu_flags_t         flags;
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0] macc;

   logic [WIDTH:0]     add_full;
   logic [WIDTH:0]     sub_full;
   logic [WIDTH-1:0]   sc_res;
   logic               sc_carry;
   logic               sc_ovf;
   logic               sc_err;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;

   function automatic alu_flags_t mk_flags(input logic [WIDTH-1:0] r, input logic c,
                                           input logic v);
      alu_flags_t f;
      f.zero  = (r == '0);
      f.neg   = r[WIDTH-1];
      f.carry = c;
      f.ovf   = v;
      return f;
   endfunction

   assign op        = alu_op_t'(alu_op);
   assign in_ready  = (state == ST_IDLE);
   assign zero      = flags.zero;
   assign neg       = flags.neg;
   assign carry     = flags.carry;
   assign ovf       = flags.ovf;

   // Single-cycle datapath straight off the input operands.
   always_comb begin
      add_full = {1'b0, a} + {1'b0, b};
      sub_full = {1'b0, a} - {1'b0, b};
      sc_res   = '0;
      sc_carry = 1'b0;
      sc_ovf   = 1'b0;
      sc_err   = 1'b0;
      case (op)
         ADDA: begin
            sc_res   = add_full[WIDTH-1:0];
            sc_carry = add_full[WIDTH];
            sc_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
         end
         SUBA: begin
            sc_res   = sub_full[WIDTH-1:0];
            sc_carry = sub_full[WIDTH];
            sc_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
         end
         MULA: sc_res = '0;
         DIVA: sc_err = 1'b1;  // only reaches the output when the divider is compiled out
         ANDA: sc_res = a & b;
         ORA:  sc_res = a | b;
         XORA: sc_res = a ^ b;
         NOTA: sc_res = ~a;
         default: sc_res = '0;
      endcase
   end

   // Shift-add step: low half holds the remaining multiplier bits, high half the partial sum.
   always_comb begin
      mul_sum  = {1'b0, macc[2*WIDTH-1:WIDTH]} + (macc[0] ? {1'b0, mcand} : '0);
      mul_next = {mul_sum, macc[WIDTH-1:1]};
   end

`ifdef ALU_DIV_EN
   logic             div_start;
   logic             div_done;
   logic             div_zero;
   logic [WIDTH-1:0] div_q;

   assign div_start = in_ready && in_valid && (op == DIVA);

   alu_divider #(
      .WIDTH(WIDTH)
   ) u_div (
      .clk     (clk),
      .rst     (rst),
      .start   (div_start),
      .dividend(a),
      .divisor (b),
      .done    (div_done),
      .quotient(div_q),
      .div_zero(div_zero)
   );
`endif

   // Control FSM with registered result, flags and out_valid pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         mcand     <= '0;
         macc      <= '0;
         out_valid <= 1'b0;
         result    <= '0;
         flags     <= '0;
         div_err   <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  if (op == MULA) begin
                     mcand <= a;
                     macc  <= {{WIDTH{1'b0}}, b};
                     cnt   <= '0;
                     state <= ST_MUL;
`ifdef ALU_DIV_EN
                  end else if (op == DIVA) begin
                     state <= ST_DIV;
`endif
                  end else begin
                     out_valid <= 1'b1;
                     result    <= sc_res;
                     flags     <= mk_flags(sc_res, sc_carry, sc_ovf);
                     div_err   <= sc_err;
                  end
               end
            end
            ST_MUL: begin
               macc <= mul_next;
               cnt  <= cnt + CW'(1);
               if (cnt == LAST) begin
                  state     <= ST_DONE;
                  out_valid <= 1'b1;
                  result    <= mul_next[WIDTH-1:0];
                  flags     <= mk_flags(mul_next[WIDTH-1:0], |mul_next[2*WIDTH-1:WIDTH], 1'b0);
                  div_err   <= 1'b0;
               end
            end
            ST_DIV: begin
`ifdef ALU_DIV_EN
               if (div_done) begin
                  state     <= ST_DONE;
                  out_valid <= 1'b1;
                  result    <= div_q;
                  flags     <= mk_flags(div_q, 1'b0, 1'b0);
                  div_err   <= div_zero;
               end
`else
               state <= ST_IDLE;
`endif
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: a transaction-level reference model predicts each
// result, its flags and the cycle it must appear; directed vectors pin the model.
module tb_alu_exec;
   import cpu_pkg::*;

   localparam int unsigned W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [2:0]   alu_op = 3'd0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         out_valid;
   logic [W-1:0] result;
   logic         zero, neg, carry, ovf, div_err;

   alu_exec #(
      .WIDTH(W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .alu_op   (alu_op),
      .a        (a),
      .b        (b),
      .out_valid(out_valid),
      .result   (result),
      .zero     (zero),
      .neg      (neg),
      .carry    (carry),
      .ovf      (ovf),
      .div_err  (div_err)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, got, exp);
      end
   endtask

   typedef struct {
      int         due;
      logic [W-1:0] res;
      logic       z, n, c, v, e;
   } exp_t;

   typedef struct {
      int         cyc;
      logic [W-1:0] res;
      logic       z, n, c, v, e;
   } obs_t;

   exp_t         expq[$];
   obs_t         seen[$];
   logic [W-1:0] h_res = '0;
   logic         h_z = 0, h_n = 0, h_c = 0, h_v = 0;
   int           busy_until = 0;
   bit           mon_on = 0;
   bit           took = 0;
   int           acc_cyc = 0;

   // Reference: what an op accepted at cycle 'now' must produce, and when.
   function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] x,
                                  input logic [W-1:0] y, input int now);
      exp_t            e;
      longint unsigned ux, uy, full;
      longint          sx, sy, s, lim;
      ux = x; uy = y;
      sx = $signed(x); sy = $signed(y);
      lim = longint'(1) <<< (W - 1);
      e.due = now + 1; e.c = 0; e.v = 0; e.e = 0; e.res = '0;
      case (op)
         3'd0: begin
            full = ux + uy; e.res = full[W-1:0]; e.c = (full >> W) != 0;
            s = sx + sy; e.v = (s >= lim) || (s < -lim);
         end
         3'd1: begin
            e.res = x - y; e.c = ux < uy;
            s = sx - sy; e.v = (s >= lim) || (s < -lim);
         end
         3'd2: begin
            full = ux * uy; e.res = full[W-1:0]; e.c = (full >> W) != 0; e.due = now + W + 1;
         end
         3'd3: begin
`ifdef ALU_DIV_EN
            e.due = now + W + 1; e.e = (y == 0);
            e.res = (y == 0) ? '1 : x / y;
`else
            e.res = '0; e.e = 1;
`endif
         end
         3'd4: e.res = x & y;
         3'd5: e.res = x | y;
         3'd6: e.res = x ^ y;
         default: e.res = ~x;
      endcase
      e.z = (e.res == 0);
      e.n = e.res[W-1];
      return e;
   endfunction

   // Compare process: check this cycle's outputs, then apply this cycle's inputs to the model.
   always @(negedge clk) begin : mon
      exp_t e;
      obs_t o;
      bit   exp_ov;
      took = 0;
      if (mon_on) begin
         chk("in_ready", in_ready, cyc >= busy_until);
         exp_ov = (expq.size() > 0) && (expq[0].due == cyc);
         chk("out_valid", out_valid, exp_ov);
         if (out_valid) begin
            o.cyc = cyc; o.res = result; o.z = zero; o.n = neg; o.c = carry; o.v = ovf;
            o.e = div_err;
            seen.push_back(o);
         end
         if (exp_ov) begin
            e = expq.pop_front();
            h_res = e.res; h_z = e.z; h_n = e.n; h_c = e.c; h_v = e.v;
            chk("div_err", div_err, e.e);
         end
         while (expq.size() > 0 && expq[0].due <= cyc) void'(expq.pop_front());
         chk("result", result, h_res);
         chk("zero", zero, h_z);
         chk("neg", neg, h_n);
         chk("carry", carry, h_c);
         chk("ovf", ovf, h_v);
      end
      if (rst) begin
         expq.delete();
         h_res = '0; h_z = 0; h_n = 0; h_c = 0; h_v = 0;
         busy_until = cyc + 1;
      end else if (in_valid && cyc >= busy_until) begin
         took = 1;
         acc_cyc = cyc;
         e = model(alu_op, a, b, cyc);
         expq.push_back(e);
         if (e.due > cyc + 1) busy_until = cyc + W + 2;
      end
   end

   // Present an op and hold it until accepted; returns just after the accepting edge.
   task automatic issue(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
      int n = 0;
      alu_op = op; a = x; b = y; in_valid = 1'b1;
      do begin
         @(posedge clk);
         n++;
      end while (!took && n < 200);
      if (!took) begin
         checks++;
         errors++;
         $display("FAIL issue_timeout: op %0d got no accept, expected accept within 200 cycles",
                  op);
      end
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_seen(input int n);
      int k = 0;
      while (seen.size() < n && k < 200) begin
         @(negedge clk);
         #1;
         k++;
      end
      if (seen.size() < n) begin
         checks++;
         errors++;
         $display("FAIL wait_result: got %0d results, expected %0d", seen.size(), n);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int a0, a1, k;
      logic [2:0]   rop;
      logic [W-1:0] rx, ry;

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      mon_on = 1;
      @(negedge clk);
      #1;
      chk("reset_in_ready", in_ready, 1);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_result", result, 0);
      chk("reset_flags", {zero, neg, carry, ovf}, 0);
      chk("reset_div_err", div_err, 0);
      @(posedge clk);
      #1;

      // ADD overflow into the sign bit, then SUB to zero
      seen.delete();
      issue(3'd0, 32'h7FFF_FFFF, 32'd1);
      issue(3'd1, 32'd5, 32'd5);
      wait_seen(2);
      chk("add_res", seen[0].res, 32'h8000_0000);
      chk("add_ovf_neg_carry", {seen[0].v, seen[0].n, seen[0].c}, 3'b110);
      chk("sub_res", seen[1].res, 0);
      chk("sub_zero", seen[1].z, 1);
      chk("add_sub_spacing", seen[1].cyc - seen[0].cyc, 1);

      // back-to-back logic ops
      seen.delete();
      issue(3'd4, 32'hF0F0_F0F0, 32'hFF00_FF00);
      issue(3'd7, 32'd0, 32'd0);
      wait_seen(2);
      chk("and_res", seen[0].res, 32'hF000_F000);
      chk("not_res", seen[1].res, 32'hFFFF_FFFF);
      chk("and_not_spacing", seen[1].cyc - seen[0].cyc, 1);

      // MUL latency and stall; an ADD held during the stall is taken only afterwards
      seen.delete();
      issue(3'd2, 32'h0001_0000, 32'h0001_0000);
      a0 = acc_cyc;
      issue(3'd0, 32'd1, 32'd1);
      a1 = acc_cyc;
      wait_seen(2);
      chk("mul_latency", seen[0].cyc - a0, 33);
      chk("mul_res", seen[0].res, 0);
      chk("mul_carry_zero", {seen[0].c, seen[0].z}, 2'b11);
      chk("held_add_accept", a1 - a0, 34);
      chk("held_add_res", seen[1].res, 2);

      // DIV normal and by zero
      seen.delete();
      issue(3'd3, 32'd100, 32'd7);
      a0 = acc_cyc;
      wait_seen(1);
`ifdef ALU_DIV_EN
      chk("div_res", seen[0].res, 14);
      chk("div_latency", seen[0].cyc - a0, 33);
      chk("div_err_clear", seen[0].e, 0);
`else
      chk("div_res", seen[0].res, 0);
      chk("div_latency", seen[0].cyc - a0, 1);
      chk("div_err_nodiv", seen[0].e, 1);
      chk("div_zero_flag", seen[0].z, 1);
`endif
      issue(3'd3, 32'd5, 32'd0);
      wait_seen(2);
`ifdef ALU_DIV_EN
      chk("div0_res", seen[1].res, 32'hFFFF_FFFF);
`else
      chk("div0_res", seen[1].res, 0);
`endif
      chk("div0_err", seen[1].e, 1);

      // reset at iteration 10 of a MUL
      seen.delete();
      issue(3'd2, 32'd123, 32'd456);
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      #1;
      chk("rst_mid_mul_ready", in_ready, 1);
      chk("rst_mid_mul_ov", out_valid, 0);
      repeat (40) @(posedge clk);
      #1;
      chk("rst_mid_mul_no_result", seen.size(), 0);
      issue(3'd0, 32'd2, 32'd3);
      a0 = acc_cyc;
      wait_seen(1);
      chk("post_rst_add", seen[0].res, 5);
      chk("post_rst_add_latency", seen[0].cyc - a0, 1);

      // random mix, checked cycle by cycle by the model
      seen.delete();
      for (int i = 0; i < 40; i++) begin
         rop = 3'($urandom_range(0, 7));
         rx  = $urandom;
         case ($urandom_range(0, 3))
            0: ry = '0;
            1: ry = W'($urandom_range(1, 300));
            default: ry = $urandom;
         endcase
         issue(rop, rx, ry);
      end
      k = 0;
      while (expq.size() > 0 && k < 200) begin
         @(posedge clk);
         k++;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("random_result_count", seen.size(), 40);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/alu_exec.md
# alu_exec

Execute-stage ALU that consumes the 3-bit ALU operation code produced by the decode-side opcode translation and carries it out on two register operands. AND/OR/XOR/NOT/ADD/SUB finish in one registered cycle. MUL and DIV run iteratively over several cycles and stall the pipeline through a ready/valid handshake. Registered condition flags feed branch resolution (BEQ/BLT/BGT/BNE) and write-back.

## Interface
- `WIDTH`, default 32: operand and result width. Must be at least 2.
- `clk`  in  1  sole clock. All logic updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  the operation on `alu_op`/`a`/`b` is presented.
- `in_ready`  out  1  unit accepts an operation this cycle.
- `alu_op`  in  3  0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 OR, 6 XOR, 7 NOT.
- `a`, `b`  in  WIDTH  operands (`b` ignored for NOT).
- `out_valid`  out  1  one-cycle pulse; result and flags are valid.
- `result`  out  WIDTH  operation result.
- `zero`, `neg`, `carry`, `ovf`  out  1 each  flags of `result`.
- `div_err`  out  1  qualified by `out_valid`. Set for divide-by-zero, or DIV issued with the divider compiled out.

## Operation
- Accept occurs when `in_valid && in_ready`. `in_ready` = (state == IDLE). Operands and opcode are latched on accept.
- States:
  - IDLE: accept an operation.
    - Ops 0,1,4–7: compute, register `result`/flags, assert `out_valid` next cycle, remain in IDLE.
    - MUL: go to MUL.
    - DIV: go to DIV.
  - MUL: shift-add multiply, one bit per cycle, WIDTH iterations. Uses an internal iteration counter, 0..WIDTH-1. Then go to DONE.
  - DIV: restoring unsigned divide, one quotient bit per cycle, WIDTH iterations. Then go to DONE.
  - DONE: drive `out_valid`=1 for exactly one cycle, then go to IDLE.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - `carry` = carry-out for ADD, borrow for SUB.
  - `ovf` = signed two's-complement overflow for ADD/SUB. 0 for all other ops.
  - MUL returns the low WIDTH bits of the unsigned product. `carry` = 1 if the high half is nonzero.
  - DIV returns the unsigned quotient. `carry` = 0.
  - `zero` = (`result` == 0). `neg` = `result[WIDTH-1]`.
- Divide by zero: `result` = all ones, `div_err`=1. Takes the full DIV latency (no early exit).
- No output backpressure. The consumer must take the result while `out_valid` is high.
- `in_valid` is ignored while `in_ready`=0. The sender must hold its operation until it is accepted.

## Timing
- Reset values:
  - state IDLE, counter 0.
  - `in_ready`=1.
  - `out_valid`=0, `result`=0, all flags 0, `div_err`=0.
- Single-cycle ops: accept at cycle N → `out_valid` at N+1. Back-to-back accepts are allowed every cycle.
- MUL/DIV: accept at N → `out_valid` at N+WIDTH+1. `in_ready`=0 from N+1 through N+WIDTH+1. `in_ready`=1 again at N+WIDTH+2.
- The cycle after `out_valid`, `out_valid` returns to 0. `result` and flags hold their last value until the next result.
- Reset asserted mid-MUL/DIV: the operation is abandoned, no `out_valid` is produced, and reset values appear the cycle after `rst` is sampled high.
- `rst` and `in_valid` high in the same cycle: reset wins and the operation is not accepted.

## Configuration
- `ALU_DIV_EN` defined:
  - Iterative divider is instantiated.
  - DIV behaves as described above.
- `ALU_DIV_EN` undefined:
  - No divider hardware.
  - DIV completes as a single-cycle op: `result`=0, `zero`=1, `div_err`=1, `in_ready` stays 1.

## Structure
- Shared package `cpu_pkg` holds:
  - the ALU opcode enum (`ADDA`…`NOTA`, same 3-bit encodings as above);
  - the state enum `alu_state_t`;
  - the flag struct (`zero`, `neg`, `carry`, `ovf`).
- The opcode translator and this block both import the encodings from `cpu_pkg`.
- One sub-module, `alu_divider`:
  - start/done handshake plus quotient and divide-by-zero outputs;
  - instantiated only under `ALU_DIV_EN`.
- The multiplier stays inline in `alu_exec`.

## Test plan
- ADD a=0x7FFFFFFF, b=1 → next cycle `result`=0x80000000, `ovf`=1, `neg`=1, `carry`=0. Then SUB a=5, b=5 → `result`=0, `zero`=1.
- Back-to-back AND 0xF0F0_F0F0 & 0xFF00_FF00, then NOT 0 → `out_valid` on two consecutive cycles with 0xF000_F000, then 0xFFFF_FFFF. `in_ready` stays 1.
- MUL 0x10000 × 0x10000 (WIDTH=32) → `out_valid` exactly 33 cycles after accept, `result`=0, `carry`=1, `zero`=1. `in_ready`=0 over the 32 intervening cycles; a new `in_valid` asserted then is not accepted.
- DIV 100 / 7 → `result`=14 after 33 cycles. DIV 5 / 0 → `result`=0xFFFF_FFFF, `div_err`=1. Without `ALU_DIV_EN`: DIV 100 / 7 → next cycle `result`=0, `div_err`=1.
- Assert `rst` for one cycle at iteration 10 of a MUL → no `out_valid`, `in_ready`=1 the following cycle. A subsequent ADD 2+3 returns 5 one cycle after accept.
- Random mix of ops against a reference model: each accepted op produces exactly one `out_valid`, in order, with matching result and flags.
